// File: rtl/mac_row_accumulator_pkg.sv
// Shared config encodings, FSM states and per-mode row tables for the row accumulator.
// Pure declarations: no latency, no flow control.
package mac_row_accumulator_pkg;

    localparam logic [1:0] CFG_SINGLE = 2'b00;
    localparam logic [1:0] CFG_DUAL   = 2'b01;
    localparam logic [1:0] CFG_QUAD   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_SINGLE,
        MODE_DUAL,
        MODE_QUAD
    } mode_t;

    // The reserved encoding 2'b11 behaves as single.
    function automatic mode_t decode_cfg(input logic [1:0] cfg_val);
        case (cfg_val)
            CFG_DUAL: return MODE_DUAL;
            CFG_QUAD: return MODE_QUAD;
            default:  return MODE_SINGLE;
        endcase
    endfunction

    function automatic logic [1:0] last_row_idx(input mode_t mode);
        case (mode)
            MODE_DUAL: return 2'd1;
            MODE_QUAD: return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mac_row_accumulator_shift_add.sv
// Masks a row product to the mode's row width, shifts it by k*MIN_W and adds it to acc.
// Combinational, no flow control; the sum is truncated to the mode's result width.
module n_bit_adder #(
    parameter int N = 64
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o
);
    assign sum_o = a_i + b_i;
endmodule

module mac_row_shift_add
    import mac_row_accumulator_pkg::*;
#(
    parameter int MIN_W = 8,
    parameter int INT_W = 5 * MIN_W,
    parameter int ACC_W = 8 * MIN_W
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [INT_W-1:0] row_i,
    input  logic [1:0]       idx_i,
    input  mode_t            mode_i,
    output logic [ACC_W-1:0] sum_o
);
    localparam logic [ACC_W-1:0] ONES = '1;

    logic [ACC_W-1:0] row_mask;
    logic [ACC_W-1:0] res_mask;
    logic [ACC_W-1:0] row_ext;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] raw_sum;
    logic [31:0]      shamt;

    always_comb begin
        row_mask = ONES >> (ACC_W - 2 * MIN_W);
        res_mask = ONES >> (ACC_W - 2 * MIN_W);
        case (mode_i)
            MODE_DUAL: begin
                row_mask = ONES >> (ACC_W - 3 * MIN_W);
                res_mask = ONES >> (ACC_W - 4 * MIN_W);
            end
            MODE_QUAD: begin
                row_mask = ONES >> (ACC_W - 5 * MIN_W);
                res_mask = ONES;
            end
            default: ;
        endcase
    end

    assign row_ext = ACC_W'(row_i);
    assign shamt   = {30'd0, idx_i} * MIN_W;
    assign addend  = (row_ext & row_mask) << shamt;

    n_bit_adder #(.N(ACC_W)) u_adder (
        .a_i   (acc_i),
        .b_i   (addend),
        .sum_o (raw_sum)
    );

    assign sum_o = raw_sum & res_mask;

endmodule

// File: rtl/mac_row_accumulator.sv
// Accumulates 1/2/4 shifted row products into one result; out_valid rises the cycle after the last row.
// Rows stall (row_ready=0) while a finished result waits for out_ready.
module mac_row_accumulator
    import mac_row_accumulator_pkg::*;
#(
    parameter int MAC_CONF_WIDTH = 2,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH,
    parameter int MAC_ACC_WIDTH  = 8 * MAC_MIN_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic [MAC_CONF_WIDTH-1:0] cfg,
    input  logic                      row_valid,
    output logic                      row_ready,
    input  logic [MAC_INT_WIDTH-1:0]  row_data,
    output logic [1:0]                row_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAC_ACC_WIDTH-1:0]  out_data,
    output logic                      busy
);
    state_t                   state_q, state_d;
    mode_t                    cfg_q, cfg_d;
    mode_t                    mode_eff;
    logic [MAC_ACC_WIDTH-1:0] acc_q, acc_d;
    logic [MAC_ACC_WIDTH-1:0] sum;
    logic [1:0]               idx_q, idx_d;
    logic                     row_hs;
    logic                     out_hs;
    logic                     last_row;

    assign row_ready = (state_q != S_DONE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign row_idx   = idx_q;
    assign out_data  = acc_q;

    assign row_hs = row_valid & row_ready;
    assign out_hs = out_valid & out_ready;

    // The live cfg input only matters for the first row; afterwards the latched mode rules.
    assign mode_eff = (state_q == S_IDLE) ? decode_cfg(cfg[1:0]) : cfg_q;
    assign last_row = (idx_q == last_row_idx(mode_eff));

    mac_row_shift_add #(
        .MIN_W (MAC_MIN_WIDTH),
        .INT_W (MAC_INT_WIDTH),
        .ACC_W (MAC_ACC_WIDTH)
    ) u_shift_add (
        .acc_i  (acc_q),
        .row_i  (row_data),
        .idx_i  (idx_q),
        .mode_i (mode_eff),
        .sum_o  (sum)
    );

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        if (clear) begin
            state_d = S_IDLE;
            cfg_d   = MODE_SINGLE;
            acc_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_ACCUM: begin
                    if (row_hs) begin
                        acc_d = sum;
                        cfg_d = mode_eff;
                        if (last_row) begin
                            state_d = S_DONE;
                            idx_d   = '0;
                        end else begin
                            state_d = S_ACCUM;
                            idx_d   = idx_q + 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_hs) begin
                        state_d = S_IDLE;
                        acc_d   = '0;
                        idx_d   = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cfg_q   <= MODE_SINGLE;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_mac_row_accumulator.sv
// Bench for mac_row_accumulator: spec vectors, hand-written corner sequences, randomized products.
module tb_mac_row_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [1:0]  cfg;
    logic        row_valid;
    logic        row_ready;
    logic [39:0] row_data;
    logic [1:0]  row_idx;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [1:0]        cfg;
        logic [3:0][39:0]  rows;
        logic [63:0]       exp;
    } vec_t;

    mac_row_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .cfg       (cfg),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic int nrows(input logic [1:0] c);
        case (c)
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 1;
        endcase
    endfunction

    // Reference: sum of masked rows weighted by 256^k, reduced modulo 2^(result width).
    function automatic logic [63:0] model(input logic [1:0] c, input logic [3:0][39:0] r);
        int           rb;
        int           wb;
        logic [127:0] acc;
        case (c)
            2'b01:   begin rb = 24; wb = 32; end
            2'b10:   begin rb = 40; wb = 64; end
            default: begin rb = 16; wb = 16; end
        endcase
        acc = '0;
        for (int k = 0; k < nrows(c); k++)
            acc = acc + (({88'd0, r[k]} & ((128'd1 << rb) - 128'd1)) << (8 * k));
        acc = acc & ((128'd1 << wb) - 128'd1);
        return acc[63:0];
    endfunction

    // Starts and ends on a falling edge; returns after the row has been taken.
    task automatic send_row(input logic [39:0] d);
        int n;
        row_valid = 1'b1;
        row_data  = d;
        n = 0;
        while (!row_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("row_ready_wait", {63'd0, row_ready}, 64'd1);
        @(negedge clk);
        row_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_idle_busy"},  {63'd0, busy},      64'd0);
        check({tag, "_idle_rdy"},   {63'd0, row_ready}, 64'd1);
        check({tag, "_idle_idx"},   {62'd0, row_idx},   64'd0);
        check({tag, "_idle_data"},  out_data,           64'd0);
    endtask

    task automatic run_product(input logic [1:0] c, input logic [3:0][39:0] r,
                               input logic [63:0] exp, input string tag, input bit gaps);
        int n;
        n   = nrows(c);
        cfg = c;
        for (int k = 0; k < n; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_row(r[k]);
            if (k < n - 1) begin
                check({tag, "_mid_idx"},   {62'd0, row_idx},   64'(k + 1));
                check({tag, "_mid_valid"}, {63'd0, out_valid}, 64'd0);
                check({tag, "_mid_busy"},  {63'd0, busy},      64'd1);
            end
        end
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_data"},  out_data,           exp);
        check({tag, "_rdy"},   {63'd0, row_ready}, 64'd0);
        check({tag, "_busy"},  {63'd0, busy},      64'd1);
        if (gaps) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check({tag, "_hold_data"}, out_data, exp);
        end
        consume();
        check_idle(tag);
    endtask

    vec_t              vecs [7];
    logic [3:0][39:0]  r;
    logic [1:0]        c;
    logic [63:0]       qexp;

    initial begin
        vecs[0] = '{2'b00, {40'd0, 40'd0, 40'd0, 40'hAB_CDEF_FE01}, 64'h0000_0000_0000_FE01};
        vecs[1] = '{2'b01, {40'd0, 40'd0, 40'h00_0000_0001, 40'h00_0000_1234}, 64'h0000_0000_0000_1334};
        vecs[2] = '{2'b10, {4{40'hFF_FFFF_FFFF}}, 64'h0101_00FF_FEFE_FEFF};
        vecs[3] = '{2'b10, {4{40'h00_0000_0001}}, 64'h0000_0000_0101_0101};
        vecs[4] = '{2'b11, {40'd0, 40'd0, 40'd0, 40'hFF_FFFF_1234}, 64'h0000_0000_0000_1234};
        vecs[5] = '{2'b01, {40'd0, 40'd0, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF}, 64'h0000_0000_00FF_FEFF};
        vecs[6] = '{2'b10, {40'h80_0000_0000, 40'd0, 40'd0, 40'd1}, 64'h8000_0000_0000_0001};

        rst = 1'b1; clear = 1'b0; cfg = 2'b00; row_valid = 1'b0;
        row_data = '0; out_ready = 1'b0;
        #12;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_product(vecs[i].cfg, vecs[i].rows, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);

        // Backpressure, then a row held across the consuming cycle.
        qexp = 64'h0101_00FF_FEFE_FEFF;
        cfg = 2'b10;
        for (int k = 0; k < 4; k++) send_row(40'hFF_FFFF_FFFF);
        row_valid = 1'b1;
        row_data  = 40'h00_0000_0001;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_data",  out_data,           qexp);
            check("bp_rdy",   {63'd0, row_ready}, 64'd0);
            @(negedge clk);
        end
        cfg       = 2'b00;
        row_data  = 40'h12_3456_789A;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_idle("bp_after");
        @(negedge clk);
        row_valid = 1'b0;
        check("bp_next_valid", {63'd0, out_valid}, 64'd1);
        check("bp_next_data",  out_data,           64'h789A);
        consume();
        check_idle("bp_next");

        // Abort with clear (row offered in the same cycle must be dropped).
        cfg = 2'b10;
        send_row(40'hFF_FFFF_FFFF);
        send_row(40'hFF_FFFF_FFFF);
        check("abort_busy", {63'd0, busy},    64'd1);
        check("abort_idx",  {62'd0, row_idx}, 64'd2);
        clear     = 1'b1;
        row_valid = 1'b1;
        row_data  = 40'h00_0000_0007;
        @(negedge clk);
        clear     = 1'b0;
        row_valid = 1'b0;
        check_idle("clear");
        run_product(2'b10, {4{40'h1}}, 64'h0000_0000_0101_0101, "post_clear", 1'b0);

        // Abort with asynchronous reset.
        send_row(40'hFF_FFFF_FFFF);
        send_row(40'hFF_FFFF_FFFF);
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_product(2'b10, {4{40'h1}}, 64'h0000_0000_0101_0101, "post_rst", 1'b0);

        // cfg changes after the first row are ignored.
        cfg = 2'b10;
        send_row(40'hFF_FFFF_FFFF);
        cfg = 2'b00;
        check("hold_valid0", {63'd0, out_valid}, 64'd0);
        check("hold_idx",    {62'd0, row_idx},   64'd1);
        for (int k = 1; k < 4; k++) send_row(40'hFF_FFFF_FFFF);
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_data",  out_data,           64'h0101_00FF_FEFE_FEFF);
        consume();
        check_idle("hold");

        for (int i = 0; i < 40; i++) begin
            c = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) r[k] = {8'($urandom), 32'($urandom)};
            run_product(c, r, model(c, r), "rand", 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
